// File: rtl/estu_pkg.sv
// Shared definitions for the spike serializer family: FSM state
// encodings and the ceil(log2) helper used to size counters.
package estu_pkg;

   // Serializer FSM states
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // Number of bits needed to index n distinct items (ceil(log2(n)))
   function automatic int unsigned clogb2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/spike_word_fifo.sv
// Small synchronous word FIFO for spike_p2s. DEPTH must be a power of
// two so the pointers wrap naturally; count is one bit wider than the
// pointers so that full and empty are distinguishable.
module spike_word_fifo
   import estu_pkg::*;
#(
   parameter int unsigned W     = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  push,
   input  logic                  pop,
   input  logic [W-1:0]          din,
   output logic [W-1:0]          dout,
   output logic                  full,
   output logic                  empty,
   output logic [clogb2(DEPTH):0] count
);

   localparam int unsigned PTR_W = clogb2(DEPTH);
   localparam int unsigned CNT_W = clogb2(DEPTH) + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy update; a simultaneous push and pop nets to zero
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/spike_p2s.sv
// spike_p2s: buffers parallel spike words and emits them one bit per
// enabled cycle, LSB first. Optional frame tracking (frame counter and
// frame_last port) is compiled in with SPIKE_P2S_FRAME_CNT_EN.
module spike_p2s
   import estu_pkg::*;
#(
   parameter int unsigned PAR_W      = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FRAME_LEN  = 717
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rst_fifo,
   input  logic             en,
   input  logic [PAR_W-1:0] spike_p,
   input  logic             valid,
   output logic             ready,
   output logic             spike_s,
   output logic             spike_valid,
   output logic             busy,
   output logic             overflow
`ifdef SPIKE_P2S_FRAME_CNT_EN
   ,
   output logic             frame_last
`endif
);

   localparam int unsigned IDX_W = clogb2(PAR_W);
   localparam int unsigned CNT_W = clogb2(FIFO_DEPTH) + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAR_W - 1);

   if (PAR_W < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       FRAME_LEN < 1) begin : g_bad_param
      $error("spike_p2s: PAR_W>=2, FIFO_DEPTH power of two >=2, FRAME_LEN>=1");
   end

   logic [0:0]       state;
   logic [PAR_W-1:0] word_q;
   logic [IDX_W-1:0] idx;

   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [PAR_W-1:0] fifo_dout;
   logic             push;
   logic             pop;
   logic             last_bit;
   logic             load;

   // Handshake and shifter control; ready looks only at registered occupancy
   always_comb begin
      ready    = !fifo_full && !rst;
      push     = valid && ready && !rst_fifo;
      last_bit = (state == ST_SHIFT) && en && (idx == IDX_LAST);
      load     = !fifo_empty && ((state == ST_IDLE) || last_bit);
      pop      = load && !rst && !rst_fifo;
   end

   spike_word_fifo #(
      .W     (PAR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clr   (rst || rst_fifo),
      .push  (push),
      .pop   (pop),
      .din   (spike_p),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // FSM, shifter word, bit index and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         word_q   <= '0;
         idx      <= '0;
         overflow <= 1'b0;
      end else if (rst_fifo) begin
         state  <= ST_IDLE;
         word_q <= '0;
         idx    <= '0;
      end else begin
         if (valid && !ready) overflow <= 1'b1;
         if (load) begin
            state  <= ST_SHIFT;
            word_q <= fifo_dout;
            idx    <= '0;
         end else if (state == ST_SHIFT && en) begin
            if (idx == IDX_LAST) state <= ST_IDLE;
            else                 idx   <= idx + 1'b1;
         end
      end
   end

   // Serial outputs are decoded from registered state only
   always_comb begin
      spike_valid = (state == ST_SHIFT);
      spike_s     = spike_valid ? word_q[idx] : 1'b0;
      busy        = (fifo_count != '0) || (state == ST_SHIFT);
   end

`ifdef SPIKE_P2S_FRAME_CNT_EN
   localparam int unsigned FR_W = (FRAME_LEN > 1) ? clogb2(FRAME_LEN) : 1;
   localparam logic [FR_W-1:0] FR_LAST = FR_W'(FRAME_LEN - 1);

   logic [FR_W-1:0] frame_cnt;

   // Position of the current serial bit within the layer frame
   always_ff @(posedge clk) begin
      if (rst || rst_fifo)            frame_cnt <= '0;
      else if (state == ST_SHIFT && en) frame_cnt <= (frame_cnt == FR_LAST) ? '0 : frame_cnt + 1'b1;
   end

   assign frame_last = spike_valid && (frame_cnt == FR_LAST);
`endif

endmodule

// File: tb/tb_spike_p2s.sv
// Directed bench for spike_p2s with a queue-based reference model that
// is compared against the DUT outputs on every falling clock edge.
module tb_spike_p2s;

   localparam int PAR_W      = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int FRAME_LEN  = 5;

   logic             clk;
   logic             rst;
   logic             rst_fifo;
   logic             en;
   logic [PAR_W-1:0] spike_p;
   logic             valid;
   logic             ready;
   logic             spike_s;
   logic             spike_valid;
   logic             busy;
   logic             overflow;
`ifdef SPIKE_P2S_FRAME_CNT_EN
   logic             frame_last;
`endif

   spike_p2s #(
      .PAR_W      (PAR_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FRAME_LEN  (FRAME_LEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rst_fifo    (rst_fifo),
      .en          (en),
      .spike_p     (spike_p),
      .valid       (valid),
      .ready       (ready),
      .spike_s     (spike_s),
      .spike_valid (spike_valid),
      .busy        (busy),
      .overflow    (overflow)
`ifdef SPIKE_P2S_FRAME_CNT_EN
      ,
      .frame_last  (frame_last)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a word queue plus the queue of bits still to emit
   logic [PAR_W-1:0] m_fifo[$];
   bit               m_bits[$];
   bit               m_ovf  = 1'b0;
   int               m_fcnt = 0;
   bit               m_acc;
   logic [PAR_W-1:0] m_w;

   always @(posedge clk) begin
      if (rst) begin
         m_fifo.delete();
         m_bits.delete();
         m_ovf  = 1'b0;
         m_fcnt = 0;
      end else if (rst_fifo) begin
         m_fifo.delete();
         m_bits.delete();
         m_fcnt = 0;
      end else begin
         m_acc = valid && (m_fifo.size() < FIFO_DEPTH);
         if (valid && !m_acc) m_ovf = 1'b1;
         if (m_bits.size() != 0 && en) begin
            void'(m_bits.pop_front());
            m_fcnt = (m_fcnt + 1) % FRAME_LEN;
         end
         if (m_bits.size() == 0 && m_fifo.size() != 0) begin
            m_w = m_fifo.pop_front();
            for (int i = 0; i < PAR_W; i++) m_bits.push_back(m_w[i]);
         end
         if (m_acc) m_fifo.push_back(spike_p);
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",       ready,       (m_fifo.size() < FIFO_DEPTH) && !rst);
         check("spike_valid", spike_valid, m_bits.size() != 0);
         check("spike_s",     spike_s,     (m_bits.size() != 0) ? m_bits[0] : 1'b0);
         check("busy",        busy,        (m_fifo.size() != 0) || (m_bits.size() != 0));
         check("overflow",    overflow,    m_ovf);
`ifdef SPIKE_P2S_FRAME_CNT_EN
         check("frame_last",  frame_last,
               (m_bits.size() != 0) && (m_fcnt == FRAME_LEN - 1));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] words8;
   logic [7:0] stream8;
   logic [5:0] words6;
   logic [5:0] stream6;
   logic [9:0] fill_w;

   initial begin
      rst = 1'b1; rst_fifo = 1'b0; en = 1'b0; valid = 1'b0; spike_p = '0;

      // Reset state
      tick();
      chk_en = 1'b1;
      check("rst_ready_low", ready, 1'b0);
      check("rst_spike_valid", spike_valid, 1'b0);
      check("rst_spike_s", spike_s, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      rst = 1'b0;
      tick();
      check("post_rst_ready", ready, 1'b1);

      // Single word 2'b10 into an idle block
      en = 1'b1; valid = 1'b1; spike_p = 2'b10;
      tick();
      valid = 1'b0;
      check("single_fill_valid", spike_valid, 1'b0);
      check("single_fill_busy", busy, 1'b1);
      tick();
      check("single_b0_valid", spike_valid, 1'b1);
      check("single_b0", spike_s, 1'b0);
      tick();
      check("single_b1_valid", spike_valid, 1'b1);
      check("single_b1", spike_s, 1'b1);
      tick();
      check("single_done_valid", spike_valid, 1'b0);
      check("single_done_busy", busy, 1'b0);

      // Four words back-to-back: 01, 11, 00, 10
      words8  = {2'b10, 2'b00, 2'b11, 2'b01};
      stream8 = 8'b1000_1101;
      for (int k = 0; k < 10; k++) begin
         if (k < 4) begin
            valid = 1'b1; spike_p = words8[2*k +: 2];
         end else begin
            valid = 1'b0;
         end
         tick();
         if (k >= 1 && k <= 8) begin
            check("b2b_valid", spike_valid, 1'b1);
            check("b2b_bit", spike_s, stream8[k-1]);
         end else begin
            check("b2b_gap", spike_valid, 1'b0);
         end
      end

      // Fill with en=0: one word sits in the shifter, four in the FIFO
      en = 1'b0;
      fill_w = {2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
      for (int k = 0; k < 5; k++) begin
         valid = 1'b1; spike_p = fill_w[2*k +: 2];
         tick();
      end
      check("full_ready", ready, 1'b0);
      check("full_held_bit", spike_s, 1'b1);
      spike_p = 2'b11;
      tick();
      valid = 1'b0;
      check("ovf_set", overflow, 1'b1);
      en = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      check("ovf_sticky", overflow, 1'b1);
      check("drain_busy", busy, 1'b0);

      // en pattern 1,0,0,1 mid-word on word 2'b10
      valid = 1'b1; spike_p = 2'b10;
      tick();
      valid = 1'b0;
      tick();
      check("hold_b0", spike_s, 1'b0);
      en = 1'b0;
      tick();
      check("hold1_valid", spike_valid, 1'b1);
      check("hold1_bit", spike_s, 1'b0);
      tick();
      check("hold2_bit", spike_s, 1'b0);
      en = 1'b1;
      tick();
      check("resume_bit", spike_s, 1'b1);
      tick();
      check("resume_done", spike_valid, 1'b0);

      // rst_fifo after bit 0 with two words buffered
      valid = 1'b1; spike_p = 2'b10;
      tick();
      spike_p = 2'b01;
      tick();
      spike_p = 2'b11;
      tick();
      check("pre_flush_bit1", spike_s, 1'b1);
      rst_fifo = 1'b1; spike_p = 2'b01;
      tick();
      rst_fifo = 1'b0; valid = 1'b0;
      check("flush_valid", spike_valid, 1'b0);
      check("flush_busy", busy, 1'b0);
      check("flush_ovf_kept", overflow, 1'b1);
      check("flush_ready", ready, 1'b1);
      for (int k = 0; k < 3; k++) tick();
      check("flush_quiet", spike_valid, 1'b0);
      valid = 1'b1; spike_p = 2'b01;
      tick();
      valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();

      // Reset clears overflow
      rst = 1'b1;
      tick();
      check("rst2_ready_low", ready, 1'b0);
      check("rst2_ovf", overflow, 1'b0);
      rst = 1'b0;
      tick();

      // Three words 01, 10, 11 -> frame of 5 ends on the fifth bit
      words6  = {2'b11, 2'b10, 2'b01};
      stream6 = 6'b111001;
      for (int k = 0; k < 8; k++) begin
         if (k < 3) begin
            valid = 1'b1; spike_p = words6[2*k +: 2];
         end else begin
            valid = 1'b0;
         end
         tick();
         if (k >= 1 && k <= 6) begin
            check("frame_bit", spike_s, stream6[k-1]);
`ifdef SPIKE_P2S_FRAME_CNT_EN
            check("frame_last_lit", frame_last, (k - 1) == 4);
`endif
         end else if (k == 7) begin
            check("frame_idle", spike_valid, 1'b0);
         end
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
